// File: rtl/nn_pkg.sv
// nn_pkg: shared sizing constants and types for the neuron datapath.
package nn_pkg;
  localparam int N_INPUTS = 784;
  localparam int ADDR_W = 10;
  localparam int W_W = 8;
  localparam int PIX_W = 8;
  localparam int ACC_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} seq_state_t;
  typedef logic signed [W_W-1:0] weight_t;
  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic signed [ACC_W-1:0] acc_t;
endpackage

// File: rtl/mac_unit.sv
// mac_unit: signed weight times unsigned pixel, accumulated with wrap-around.
module mac_unit
  import nn_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_i,
  input  logic    clr_i,
  input  logic    en_i,
  input  weight_t a_i,
  input  pixel_t  b_i,
  output acc_t    acc_o
);
  acc_t prod;
  // pixel gets a zero sign bit so it multiplies as a non-negative value
  always_comb prod = acc_t'(a_i) * acc_t'($signed({1'b0, b_i}));
  always_ff @(posedge clk_i)
    if (rst_i || clr_i) acc_o <= '0;
    else if (en_i) acc_o <= acc_o + prod;
endmodule

// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer: streams pixels against the weight ROM and hands off one dot product.
module neuron_mac_sequencer
  import nn_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  input  logic              pixel_valid_i,
  input  logic [PIX_W-1:0]  pixel_i,
  output logic              pixel_ready_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [W_W-1:0]    weight_i,
  output logic              sum_valid_o,
  output logic [ACC_W-1:0]  sum_o,
  input  logic              sum_ready_i
);
  seq_state_t state;
  logic [ADDR_W-1:0] idx;
  pixel_t pix_q;
  logic pipe_v, accept, last;
  acc_t acc;
  assign pixel_ready_o = state == RUN;
  assign busy_o = state != IDLE;
  assign accept = pixel_valid_i & pixel_ready_o;
  assign last = idx == ADDR_W'(N_INPUTS - 1);
  // the ROM samples this address on the accept edge, so weight and pix_q line up a cycle later
  assign rom_addr_o = idx;
  mac_unit u_mac (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(state == IDLE && start_i),
    .en_i(pipe_v),
    .a_i(weight_t'(weight_i)),
    .b_i(pix_q),
    .acc_o(acc)
  );
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      idx <= '0;
      pix_q <= '0;
      pipe_v <= 1'b0;
      sum_valid_o <= 1'b0;
      sum_o <= '0;
    end else begin
      pipe_v <= accept;
      if (accept) begin
        pix_q <= pixel_i;
        idx <= last ? '0 : idx + 1'b1;
      end
      unique case (state)
        IDLE: if (start_i) begin
          state <= RUN;
          idx <= '0;
        end
        RUN: if (accept && last) state <= DRAIN;
        DRAIN: state <= DONE;
        DONE: if (!sum_valid_o) begin
          sum_o <= acc;
          sum_valid_o <= 1'b1;
        end else if (sum_ready_i) begin
          state <= IDLE;
          sum_valid_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// tb_neuron_mac_sequencer: directed and randomized dot products against a plain-arithmetic model.
module tb_neuron_mac_sequencer;
  logic clk = 0, rst = 1, start = 0, pixel_valid = 0, sum_ready = 1;
  logic [7:0] pixel = 0, weight = 0;
  logic busy, pixel_ready, sum_valid;
  logic [9:0] rom_addr;
  logic [31:0] sum;
  logic signed [7:0] rom [0:1023];
  logic [7:0] pix [0:783];
  int n_assert = 0, n_fail = 0;
  neuron_mac_sequencer dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy),
    .pixel_valid_i(pixel_valid), .pixel_i(pixel), .pixel_ready_o(pixel_ready),
    .rom_addr_o(rom_addr), .weight_i(weight), .sum_valid_o(sum_valid),
    .sum_o(sum), .sum_ready_i(sum_ready)
  );
  always #5 clk = ~clk;
  always @(posedge clk) weight <= rom[rom_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, " rom_addr"}, 32'(rom_addr), 0);
    chk({tag, " pixel_ready"}, 32'(pixel_ready), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " sum_valid"}, 32'(sum_valid), 0);
    chk({tag, " sum"}, sum, 0);
  endtask
  // mode 0: valid always, 1: toggling, 2: random; entered and left at a negedge
  task automatic run_dot(input string tag, input int mode, input int hold, input bit pulses);
    int s, k, n, last;
    bit seen;
    s = 0;
    for (int i = 0; i < 784; i++) s += int'(rom[i]) * int'(pix[i]);
    k = 0; n = 0; last = -1; seen = 0;
    sum_ready = (hold == 0);
    start = 1;
    pixel_valid = 1;
    @(posedge clk);
    while (!seen && n < 4000) begin
      @(negedge clk);
      if (sum_valid) seen = 1;
      else begin
        chk({tag, " busy"}, 32'(busy), 1);
        chk({tag, " pixel_ready"}, 32'(pixel_ready), 32'(k < 784));
        chk({tag, " rom_addr"}, 32'(rom_addr), k < 784 ? k : 0);
        start = pulses && n == 100;
        pixel_valid = mode == 0 ? 1'b1 : mode == 1 ? n[0] : 1'($urandom_range(0, 1));
        pixel = k < 784 ? pix[k] : 8'($urandom);
        @(posedge clk);
        n++;
        if (pixel_valid && k < 784) begin
          k++;
          if (k == 784) last = n;
        end
      end
    end
    chk({tag, " completed"}, 32'(seen), 1);
    chk({tag, " latency"}, n, last + 2);
    if (mode == 0) chk({tag, " latency786"}, n, 786);
    if (mode == 1) chk({tag, " bubble latency"}, 32'(n > 1500), 1);
    chk({tag, " sum"}, sum, 32'(s));
    for (int h = 0; h < hold; h++) begin
      start = h == 3;
      @(posedge clk);
      @(negedge clk);
      chk({tag, " hold valid"}, 32'(sum_valid), 1);
      chk({tag, " hold sum"}, sum, 32'(s));
      chk({tag, " hold busy"}, 32'(busy), 1);
      chk({tag, " hold ready"}, 32'(pixel_ready), 0);
    end
    start = 0;
    sum_ready = 1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, " post valid"}, 32'(sum_valid), 0);
    chk({tag, " post busy"}, 32'(busy), 0);
    chk({tag, " post sum"}, sum, 32'(s));
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 8'(i);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 1;
    for (int i = 0; i < 784; i++) pix[i] = 1;
    run_dot("ones", 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 1024; i++) rom[i] = -128;
    for (int i = 0; i < 784; i++) pix[i] = 255;
    run_dot("extreme", 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 1024; i++) rom[i] = 8'(i % 7 - 3);
    for (int i = 0; i < 784; i++) pix[i] = 8'(i % 256);
    run_dot("toggle", 1, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 784; i++) pix[i] = 8'($urandom);
    run_dot("random_hold", 2, 10, 1);
    @(negedge clk);
    start = 1;
    pixel_valid = 1;
    @(posedge clk);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start = 0;
      pixel = pix[k];
      @(posedge clk);
    end
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("midreset");
    rst = 0;
    for (int i = 0; i < 1024; i++) rom[i] = 2;
    for (int i = 0; i < 784; i++) pix[i] = 3;
    run_dot("twos_threes", 0, 0, 0);
    for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 784; i++) pix[i] = 8'($urandom);
    run_dot("back_to_back", 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
